// File: rtl/posi_fra_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// posi_fra_arbiter_pkg
//   Shared definitions for the post-intra frame line-buffer arbiter:
//   picture/pixel width constants, default arbiter sizing and the
//   arbiter state encoding.
// ---------------------------------------------------------------------------
package posi_fra_arbiter_pkg;

    // Picture-width and pixel-width constants. A word address of
    // PIC_X_WIDTH+4 bits covers the 1024-entry line buffer.
    localparam int PIC_X_WIDTH = 6;
    localparam int PIXEL_WIDTH = 8;

    // Default arbiter sizing.
    localparam int POSI_ARB_ADR_W    = PIC_X_WIDTH + 4;
    localparam int POSI_ARB_DAT_W    = PIXEL_WIDTH * 4;
    localparam int POSI_ARB_DEPTH    = 4;
    localparam int POSI_ARB_MAX_WAIT = 8;

    typedef enum logic {
        POSI_ARB_SERVE = 1'b0,
        POSI_ARB_DRAIN = 1'b1
    } posi_arb_state_e;

endpackage

// File: rtl/posi_fra_arbiter_wr_fifo.sv
// ---------------------------------------------------------------------------
// posi_wr_fifo
//   DEPTH-entry register FIFO of {address, data} write requests.
//   Exposes every entry address plus a per-entry valid bit so the
//   arbiter can detect read-after-write hazards.
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset (empties FIFO)
//   push_i         write one entry (caller guarantees !full_o)
//   adr_i, dat_i   entry to push
//   pop_i          remove head entry (caller guarantees !empty_o)
//   full_o         no free entry
//   empty_o        no valid entry
//   cnt_o          number of valid entries (0..DEPTH)
//   head_adr_o     address of oldest entry
//   head_dat_o     data of oldest entry
//   ent_adr_o      address of every storage slot
//   ent_vld_o      valid bit of every storage slot
// ---------------------------------------------------------------------------
module posi_wr_fifo
    import posi_fra_arbiter_pkg::*;
#(
    parameter int ADR_W = POSI_ARB_ADR_W,
    parameter int DAT_W = POSI_ARB_DAT_W,
    parameter int DEPTH = POSI_ARB_DEPTH,
    localparam int IW   = $clog2(DEPTH),
    localparam int PW   = IW + 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        push_i,
    input  logic [ADR_W-1:0]            adr_i,
    input  logic [DAT_W-1:0]            dat_i,
    input  logic                        pop_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [PW-1:0]               cnt_o,
    output logic [ADR_W-1:0]            head_adr_o,
    output logic [DAT_W-1:0]            head_dat_o,
    output logic [DEPTH-1:0][ADR_W-1:0] ent_adr_o,
    output logic [DEPTH-1:0]            ent_vld_o
);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] vld_q,    vld_d;
    logic [ADR_W-1:0] adr_q [DEPTH];
    logic [DAT_W-1:0] dat_q [DEPTH];

    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx = wr_ptr_q[IW-1:0];
    assign rd_idx = rd_ptr_q[IW-1:0];

    // Pointers carry one extra wrap bit: equal index with differing MSB is full.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign cnt_o   = wr_ptr_q - rd_ptr_q;

    assign head_adr_o = adr_q[rd_idx];
    assign head_dat_o = dat_q[rd_idx];
    assign ent_vld_o  = vld_q;

    always_comb begin
        ent_adr_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_adr_o[i] = adr_q[i];
        end
    end

    // Push and pop never target the same slot in one cycle (that would
    // need the FIFO to be both empty and full), so the valid updates
    // cannot collide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        if (push_i) begin
            wr_ptr_d       = wr_ptr_q + PW'(1);
            vld_d[wr_idx]  = 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d       = rd_ptr_q + PW'(1);
            vld_d[rd_idx]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            adr_q[wr_idx] <= adr_i;
            dat_q[wr_idx] <= dat_i;
        end
    end

endmodule

// File: rtl/posi_fra_arbiter.sv
// ---------------------------------------------------------------------------
// posi_fra_arbiter
//   Shares the single-port post-intra frame line buffer between an intra
//   read requester and a reconstructed-row write requester. Writes are
//   queued in a small FIFO so reads normally win; the FIFO is forced out
//   when full, when it has starved for MAX_WAIT cycles, on a read-after-
//   write address hazard, or during an end-of-LCU drain.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   rd_req_i/adr_i   read request + address, held until rd_gnt_o
//   rd_gnt_o         read granted this cycle (combinational)
//   rd_vld_o         rd_dat_o valid (one cycle after grant)
//   rd_dat_o         read data (RAM passthrough)
//   wr_req_i/adr_i/dat_i  write push request
//   wr_rdy_o         FIFO accepts a push this cycle
//   drain_i          pulse: flush all pending writes
//   done_o           one-cycle pulse: drain complete
//   fra_wr_*_o       write port to the memory wrapper
//   fra_rd_*_o       read port to the memory wrapper
//   fra_rd_dat_i     read data from the memory wrapper
// ---------------------------------------------------------------------------
module posi_fra_arbiter
    import posi_fra_arbiter_pkg::*;
#(
    parameter int ADR_W    = POSI_ARB_ADR_W,
    parameter int DAT_W    = POSI_ARB_DAT_W,
    parameter int DEPTH    = POSI_ARB_DEPTH,
    parameter int MAX_WAIT = POSI_ARB_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rd_req_i,
    input  logic [ADR_W-1:0] rd_adr_i,
    output logic             rd_gnt_o,
    output logic             rd_vld_o,
    output logic [DAT_W-1:0] rd_dat_o,
    input  logic             wr_req_i,
    input  logic [ADR_W-1:0] wr_adr_i,
    input  logic [DAT_W-1:0] wr_dat_i,
    output logic             wr_rdy_o,
    input  logic             drain_i,
    output logic             done_o,
    output logic             fra_wr_ena_o,
    output logic [ADR_W-1:0] fra_wr_adr_o,
    output logic [DAT_W-1:0] fra_wr_dat_o,
    output logic             fra_rd_ena_o,
    output logic [ADR_W-1:0] fra_rd_adr_o,
    input  logic [DAT_W-1:0] fra_rd_dat_i
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    posi_arb_state_e state_q, state_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            rd_vld_q;
    logic            done_q, done_d;

    logic                        fifo_full;
    logic                        fifo_empty;
    logic [PW-1:0]               fifo_cnt;
    logic [PW-1:0]               fifo_cnt_nxt;
    logic [ADR_W-1:0]            head_adr;
    logic [DAT_W-1:0]            head_dat;
    logic [DEPTH-1:0][ADR_W-1:0] ent_adr;
    logic [DEPTH-1:0]            ent_vld;

    logic hazard;
    logic starved;
    logic serve;
    logic push;
    logic pop;
    logic gnt;

    posi_wr_fifo #(
        .ADR_W (ADR_W),
        .DAT_W (DAT_W),
        .DEPTH (DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_i     (push),
        .adr_i      (wr_adr_i),
        .dat_i      (wr_dat_i),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .cnt_o      (fifo_cnt),
        .head_adr_o (head_adr),
        .head_dat_o (head_dat),
        .ent_adr_o  (ent_adr),
        .ent_vld_o  (ent_vld)
    );

    // Read-after-write hazard: the requested address is still queued.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_adr[i] == rd_adr_i)) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & rd_req_i;
    end

    assign starved = (wait_cnt_q >= WW'(MAX_WAIT));
    assign serve   = (state_q == POSI_ARB_SERVE);

    // rstn gating keeps both memory enables low while reset is held.
    assign pop  = rstn & !fifo_empty &
                  (!serve | fifo_full | starved | hazard | !rd_req_i);
    assign gnt  = rstn & rd_req_i & serve & !pop;
    assign push = wr_req_i & wr_rdy_o;

    assign wr_rdy_o = !fifo_full & serve;
    assign rd_gnt_o = gnt;
    assign rd_vld_o = rd_vld_q;
    assign rd_dat_o = fra_rd_dat_i;
    assign done_o   = done_q;

    assign fra_wr_ena_o = pop;
    assign fra_wr_adr_o = head_adr;
    assign fra_wr_dat_o = head_dat;
    assign fra_rd_ena_o = gnt;
    assign fra_rd_adr_o = gnt ? rd_adr_i : head_adr;

    assign fifo_cnt_nxt = fifo_cnt + PW'(push) - PW'(pop);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (pop || fifo_empty) begin
            wait_cnt_d = '0;
        end else if (!starved) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
    end

    // done_o is registered: it is raised one cycle early, when the next
    // state is DRAIN and the FIFO will be empty, so it lands exactly on
    // the DRAIN cycle that sees an empty FIFO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            POSI_ARB_SERVE: if (drain_i)    state_d = POSI_ARB_DRAIN;
            POSI_ARB_DRAIN: if (fifo_empty) state_d = POSI_ARB_SERVE;
            default:                        state_d = POSI_ARB_SERVE;
        endcase
        done_d = (state_d == POSI_ARB_DRAIN) && (fifo_cnt_nxt == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= POSI_ARB_SERVE;
            wait_cnt_q <= '0;
            rd_vld_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_vld_q   <= gnt;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_posi_fra_arbiter.sv
module tb_posi_fra_arbiter;

    localparam int ADR_W = 10;
    localparam int DAT_W = 32;

    logic             clk = 1'b0;
    logic             rstn;
    logic             rd_req;
    logic [ADR_W-1:0] rd_adr;
    logic             rd_gnt;
    logic             rd_vld;
    logic [DAT_W-1:0] rd_dat;
    logic             wr_req;
    logic [ADR_W-1:0] wr_adr;
    logic [DAT_W-1:0] wr_dat;
    logic             wr_rdy;
    logic             drain;
    logic             done;
    logic             fra_wr_ena;
    logic [ADR_W-1:0] fra_wr_adr;
    logic [DAT_W-1:0] fra_wr_dat;
    logic             fra_rd_ena;
    logic [ADR_W-1:0] fra_rd_adr;
    logic [DAT_W-1:0] fra_rd_dat;

    int n_cmp = 0;
    int n_err = 0;

    posi_fra_arbiter #(
        .ADR_W    (ADR_W),
        .DAT_W    (DAT_W),
        .DEPTH    (4),
        .MAX_WAIT (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rd_req_i     (rd_req),
        .rd_adr_i     (rd_adr),
        .rd_gnt_o     (rd_gnt),
        .rd_vld_o     (rd_vld),
        .rd_dat_o     (rd_dat),
        .wr_req_i     (wr_req),
        .wr_adr_i     (wr_adr),
        .wr_dat_i     (wr_dat),
        .wr_rdy_o     (wr_rdy),
        .drain_i      (drain),
        .done_o       (done),
        .fra_wr_ena_o (fra_wr_ena),
        .fra_wr_adr_o (fra_wr_adr),
        .fra_wr_dat_o (fra_wr_dat),
        .fra_rd_ena_o (fra_rd_ena),
        .fra_rd_adr_o (fra_rd_adr),
        .fra_rd_dat_i (fra_rd_dat)
    );

    always #5 clk = ~clk;

    // Memory wrapper model: 1024x32 single-port RAM, 1-cycle read latency.
    logic [DAT_W-1:0] mem [1024];
    logic [DAT_W-1:0] ram_q;
    assign fra_rd_dat = ram_q;

    always @(posedge clk) begin
        if (fra_wr_ena) mem[fra_wr_adr] <= fra_wr_dat;
        if (fra_rd_ena) ram_q <= mem[fra_rd_adr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n_gnt;
        int n_wr;
        int n_rdy;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
        ram_q  = '0;
        rstn   = 1'b0;
        rd_req = 1'b1;
        rd_adr = 10'h010;
        wr_req = 1'b0;
        wr_adr = '0;
        wr_dat = '0;
        drain  = 1'b0;

        // Reset state, with a read request held to check gating.
        step(); step();
        probe();
        chk("rst_gnt",    32'(rd_gnt),     32'd0);
        chk("rst_rd_ena", 32'(fra_rd_ena), 32'd0);
        chk("rst_wr_ena", 32'(fra_wr_ena), 32'd0);
        chk("rst_wr_rdy", 32'(wr_rdy),     32'd1);
        chk("rst_rd_vld", 32'(rd_vld),     32'd0);
        chk("rst_done",   32'(done),       32'd0);

        // Idle read of 0x010.
        step();
        rstn = 1'b1;
        probe();
        chk("idle_gnt",    32'(rd_gnt),     32'd1);
        chk("idle_rd_ena", 32'(fra_rd_ena), 32'd1);
        chk("idle_rd_adr", 32'(fra_rd_adr), 32'h010);
        chk("idle_wr_ena", 32'(fra_wr_ena), 32'd0);
        step();
        rd_req = 1'b0;
        probe();
        chk("idle_vld", 32'(rd_vld), 32'd1);
        chk("idle_dat", rd_dat,      32'hC0DE0010);

        // Write behind continuous reads: pops after 8 stalled cycles.
        step();
        wr_req = 1'b1; wr_adr = 10'h020; wr_dat = 32'hA5A5A5A5;
        rd_req = 1'b1; rd_adr = 10'h100;
        probe();
        chk("starve_push_gnt", 32'(rd_gnt), 32'd1);
        step();
        wr_req = 1'b0;
        n_gnt = 0; n_wr = 0;
        for (int k = 1; k <= 8; k++) begin
            rd_adr = 10'h100 + 10'(k);
            probe();
            if (rd_gnt) n_gnt++;
            if (fra_wr_ena) n_wr++;
            step();
        end
        chk("starve_gnts", 32'(n_gnt), 32'd8);
        chk("starve_nowr", 32'(n_wr),  32'd0);
        probe();
        chk("starve_pop_gnt", 32'(rd_gnt),     32'd0);
        chk("starve_pop_ena", 32'(fra_wr_ena), 32'd1);
        chk("starve_pop_adr", 32'(fra_wr_adr), 32'h020);
        chk("starve_pop_dat", fra_wr_dat,      32'hA5A5A5A5);
        step();
        probe();
        chk("starve_resume", 32'(rd_gnt), 32'd1);
        step();
        rd_adr = 10'h020;
        probe();
        step();
        rd_req = 1'b0;
        probe();
        chk("starve_rdback", rd_dat, 32'hA5A5A5A5);

        // FIFO full: four pushes while reads keep the port busy.
        step();
        rd_req = 1'b1; rd_adr = 10'h200;
        n_wr = 0;
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1;
            wr_adr = 10'h040 + 10'(i);
            wr_dat = 32'hD0000000 + 32'(i);
            probe();
            if (fra_wr_ena) n_wr++;
            step();
        end
        wr_req = 1'b0;
        chk("full_fill_nowr", 32'(n_wr), 32'd0);
        probe();
        chk("full_rdy",     32'(wr_rdy),     32'd0);
        chk("full_pop_ena", 32'(fra_wr_ena), 32'd1);
        chk("full_pop_adr", 32'(fra_wr_adr), 32'h040);
        chk("full_pop_dat", fra_wr_dat,      32'hD0000000);
        chk("full_pop_gnt", 32'(rd_gnt),     32'd0);
        step();
        probe();
        chk("full_rdy_back", 32'(wr_rdy), 32'd1);
        step();
        rd_req = 1'b0;
        n_wr = 0;
        for (int i = 0; i < 3; i++) begin
            probe();
            if (fra_wr_ena) n_wr++;
            step();
        end
        chk("full_rest_pops", 32'(n_wr), 32'd3);
        probe();
        chk("full_empty_idle", 32'(fra_wr_ena), 32'd0);

        // RAW hazard on 0x030.
        step();
        wr_req = 1'b1; wr_adr = 10'h030; wr_dat = 32'h11223344;
        step();
        wr_req = 1'b0;
        rd_req = 1'b1; rd_adr = 10'h030;
        probe();
        chk("raw_gnt",    32'(rd_gnt),     32'd0);
        chk("raw_wr_ena", 32'(fra_wr_ena), 32'd1);
        chk("raw_wr_adr", 32'(fra_wr_adr), 32'h030);
        step();
        probe();
        chk("raw_gnt_after", 32'(rd_gnt),     32'd1);
        chk("raw_rd_adr",    32'(fra_rd_adr), 32'h030);
        step();
        rd_req = 1'b0;
        probe();
        chk("raw_vld", 32'(rd_vld), 32'd1);
        chk("raw_dat", rd_dat,      32'h11223344);

        // Drain with three queued entries.
        step();
        rd_req = 1'b1; rd_adr = 10'h300;
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1;
            wr_adr = 10'h050 + 10'(i);
            wr_dat = 32'hE0000000 + 32'(i);
            step();
        end
        wr_req = 1'b0;
        drain  = 1'b1;
        probe();
        chk("drain_req_gnt", 32'(rd_gnt), 32'd1);
        step();
        drain = 1'b0;
        n_wr = 0; n_gnt = 0; n_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            probe();
            if (fra_wr_ena) n_wr++;
            if (rd_gnt) n_gnt++;
            if (wr_rdy) n_rdy++;
            step();
        end
        chk("drain_pops",  32'(n_wr),  32'd3);
        chk("drain_gnts",  32'(n_gnt), 32'd0);
        chk("drain_rdys",  32'(n_rdy), 32'd0);
        probe();
        chk("drain_done",     32'(done),   32'd1);
        chk("drain_done_gnt", 32'(rd_gnt), 32'd0);
        step();
        probe();
        chk("drain_done_clr", 32'(done),   32'd0);
        chk("drain_gnt_back", 32'(rd_gnt), 32'd1);
        step();
        rd_req = 1'b0;

        // Drain with an empty FIFO.
        drain = 1'b1;
        probe();
        chk("edrain_done0", 32'(done), 32'd0);
        step();
        drain = 1'b0;
        probe();
        chk("edrain_done1", 32'(done), 32'd1);
        step();
        probe();
        chk("edrain_done2", 32'(done), 32'd0);

        // Drain and push in the same cycle: the push joins the drain.
        step();
        drain = 1'b1; wr_req = 1'b1; wr_adr = 10'h070; wr_dat = 32'h77777777;
        probe();
        chk("dpush_rdy", 32'(wr_rdy), 32'd1);
        step();
        drain = 1'b0; wr_req = 1'b0;
        probe();
        chk("dpush_pop", 32'(fra_wr_ena), 32'd1);
        chk("dpush_adr", 32'(fra_wr_adr), 32'h070);
        chk("dpush_nodone", 32'(done),    32'd0);
        step();
        probe();
        chk("dpush_done", 32'(done), 32'd1);

        // Reset mid-operation with two queued entries.
        step();
        rd_req = 1'b1; rd_adr = 10'h300;
        for (int i = 0; i < 2; i++) begin
            wr_req = 1'b1;
            wr_adr = 10'h060 + 10'(i);
            wr_dat = 32'hF0000000 + 32'(i);
            step();
        end
        wr_req = 1'b0;
        rstn   = 1'b0;
        #1;
        chk("mrst_rdy",    32'(wr_rdy),     32'd1);
        chk("mrst_vld",    32'(rd_vld),     32'd0);
        chk("mrst_wr_ena", 32'(fra_wr_ena), 32'd0);
        chk("mrst_rd_ena", 32'(fra_rd_ena), 32'd0);
        step();
        rstn   = 1'b1;
        rd_req = 1'b0;
        n_wr = 0;
        for (int i = 0; i < 4; i++) begin
            probe();
            if (fra_wr_ena) n_wr++;
            step();
        end
        chk("mrst_no_pops", 32'(n_wr), 32'd0);
        probe();
        chk("mrst_rdy_after", 32'(wr_rdy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
